// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Holds digit width, BCD limit, blank-mask and invalid-digit functions.
package seg_pkg;

  localparam int DIGIT_W    = 4;
  localparam int BCD_MAX    = 9;
  localparam int MAX_DIGITS = 8;
  localparam int MAX_W      = MAX_DIGITS * DIGIT_W;

  // Bit i set when digit i is a leading zero to be blanked.
  // Digit 0 is never blanked.
  function automatic logic [MAX_DIGITS-1:0] blank_mask(
    input logic [MAX_W-1:0] v,
    input int               digits,
    input logic             en
  );
    logic [MAX_DIGITS-1:0] m;
    logic                  z;
    m = '0;
    z = 1'b1;
    for (int i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < digits) begin
        z    = z & (v[i*DIGIT_W +: DIGIT_W] == '0);
        m[i] = en & z;
      end
    end
    return m;
  endfunction

  function automatic logic has_invalid(
    input logic [MAX_W-1:0] v,
    input int               digits
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        if (v[i*DIGIT_W +: DIGIT_W] > 4'(BCD_MAX))
          r = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Slot/digit timer for the scan driver.
// Ports: clk, rst_n in; idx, slot_start, frame_end out.
module seg_refresh_timer #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] idx,
  output logic          slot_start,
  output logic          frame_end
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          idx_last;

  assign cnt_last   = cnt == CW'(REFRESH_DIV - 1);
  assign idx_last   = idx == IW'(DIGITS - 1);
  assign slot_start = cnt == '0;
  assign frame_end  = cnt_last & idx_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed scan driver: double-buffered BCD, frame-aligned commit.
// Ports: clk, rst_n, Load, Value in; Ready, Din, Blank, An, Err out.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int BLANK_LZ    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      Load,
  input  logic [DIGIT_W*DIGITS-1:0] Value,
  output logic                      Ready,
  output logic [DIGIT_W-1:0]        Din,
  output logic                      Blank,
  output logic [DIGITS-1:0]         An,
  output logic                      Err
);

  localparam int VW = DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [IW-1:0]      idx;
  logic               slot_start;
  logic               frame_end;
  logic               pending;
  logic [VW-1:0]      shadow;
  logic [VW-1:0]      disp;
  logic [DIGITS-1:0]  bmask;
  logic               accept;
  logic [DIGITS-1:0]  an_d;
  logic [DIGIT_W-1:0] din_d;
  logic               blank_d;
  logic               lit;

  seg_refresh_timer #(
    .DIGITS     (DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .slot_start(slot_start),
    .frame_end (frame_end)
  );

  assign Ready  = ~pending;
  assign accept = Load & ~pending;
  assign bmask  = DIGITS'(blank_mask(MAX_W'(disp), DIGITS,
                                     BLANK_LZ != 0));

  // Shadow fills on accept; disp only moves at the frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      shadow  <= '0;
      disp    <= '0;
      Err     <= 1'b0;
    end else begin
      if (accept) begin
        shadow  <= Value;
        pending <= 1'b1;
      end
      if (frame_end && pending) begin
        disp    <= shadow;
        pending <= 1'b0;
        Err     <= has_invalid(MAX_W'(shadow), DIGITS);
      end
    end
  end

  always_comb begin
    an_d    = '1;
    blank_d = 1'b1;
    din_d   = '0;
    lit     = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        din_d = disp[i*DIGIT_W +: DIGIT_W];
        lit   = ~slot_start & ~bmask[i];
      end
    end
    if (lit) begin
      blank_d = 1'b0;
      for (int i = 0; i < DIGITS; i++)
        an_d[i] = ~(idx == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      An    <= '1;
      Blank <= 1'b1;
      Din   <= '0;
    end else begin
      An    <= an_d;
      Blank <= blank_d;
      Din   <= din_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver, DIGITS=4, REFRESH_DIV=4.
// Table of load vectors plus reset, discard and async-reset sequences.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Value = '0;

  logic       rdy1, blk1, err1;
  logic [3:0] din1, an1;
  logic       rdy0, blk0, err0;
  logic [3:0] din0, an0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Load(Load), .Value(Value),
    .Ready(rdy1), .Din(din1), .Blank(blk1), .An(an1), .Err(err1)
  );

  seg_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .Load(Load), .Value(Value),
    .Ready(rdy0), .Din(din0), .Blank(blk0), .An(an0), .Err(err0)
  );

  typedef struct {
    logic [15:0] value;
    bit          lz;
    logic [3:0]  lit;
    bit          err;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    bit         blank;
    logic [3:0] din;
    bit         err;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[8];

  task automatic chk(input string name,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] v,
                            input logic [3:0] lit,
                            input bit err);
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      int s;
      int c;
      s     = j / 4;
      c     = j % 4;
      e.din = v[s*4 +: 4];
      e.err = err;
      if (c != 0 && lit[s]) begin
        e.an    = ~(4'b0001 << s);
        e.blank = 1'b0;
      end else begin
        e.an    = 4'hF;
        e.blank = 1'b1;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic check_frame(input string tag, input bit lz);
    exp_t e;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s: scoreboard empty", tag);
      end else begin
        e = sbq.pop_front();
        chk({tag, "_an"},  lz ? an1 : an0, 8'(e.an));
        chk({tag, "_blk"}, lz ? blk1 : blk0, 8'(e.blank));
        chk({tag, "_din"}, lz ? din1 : din0, 8'(e.din));
        chk({tag, "_err"}, lz ? err1 : err0, 8'(e.err));
        chk({tag, "_rdy"}, rdy1, 8'd1);
      end
    end
  endtask

  // Load v, optionally offer dv while busy, then check the frame.
  task automatic do_load(input vec_t v,
                         input bit discard,
                         input logic [15:0] dv,
                         input string tag);
    int n;
    @(negedge clk);
    chk({tag, "_rdy_pre"}, rdy1, 8'd1);
    Load  = 1'b1;
    Value = v.value;
    push_frame(v.value, v.lit, v.err);
    @(negedge clk);
    chk({tag, "_rdy_fall"}, rdy1, 8'd0);
    if (discard) begin
      Value = dv;
      Load  = 1'b1;
    end else begin
      Load = 1'b0;
    end
    @(negedge clk);
    Load = 1'b0;
    n = 0;
    while (rdy1 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy_rise"}, rdy1, 8'd1);
    check_frame(tag, v.lz);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{16'h1234, 1'b1, 4'b1111, 1'b0};
    tbl[1] = '{16'h0005, 1'b1, 4'b0001, 1'b0};
    tbl[2] = '{16'h0000, 1'b1, 4'b0001, 1'b0};
    tbl[3] = '{16'h0005, 1'b0, 4'b1111, 1'b0};
    tbl[4] = '{16'h0100, 1'b1, 4'b0111, 1'b0};
    tbl[5] = '{16'h00A3, 1'b1, 4'b0011, 1'b1};
    tbl[6] = '{16'h0042, 1'b1, 4'b0011, 1'b0};
    tbl[7] = '{16'hF000, 1'b1, 4'b1111, 1'b1};

    repeat (3) begin
      @(negedge clk);
      chk("rst_an",  an1,  8'hF);
      chk("rst_blk", blk1, 8'd1);
      chk("rst_din", din1, 8'd0);
      chk("rst_rdy", rdy1, 8'd1);
      chk("rst_err", err1, 8'd0);
      chk("rst_an0", an0,  8'hF);
    end
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0001, 1'b0);
    check_frame("first", 1'b1);

    for (int k = 0; k < 8; k++)
      do_load(tbl[k], 1'b0, 16'h0, $sformatf("vec%0d", k));

    v = '{16'h1111, 1'b1, 4'b1111, 1'b0};
    do_load(v, 1'b1, 16'h2222, "discard");
    push_frame(16'h1111, 4'b1111, 1'b0);
    check_frame("discard2", 1'b1);

    @(negedge clk);
    Load  = 1'b1;
    Value = 16'h5678;
    @(negedge clk);
    Load = 1'b0;
    chk("ar_rdy_fall", rdy1, 8'd0);
    repeat (9) @(negedge clk);
    chk("ar_lit_before", an1, 8'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_an",  an1,  8'hF);
    chk("ar_blk", blk1, 8'd1);
    chk("ar_din", din1, 8'd0);
    chk("ar_rdy", rdy1, 8'd1);
    chk("ar_err", err1, 8'd0);
    chk("ar_an0", an0,  8'hF);
    @(negedge clk);
    rst_n = 1'b1;
    push_frame(16'h0000, 4'b0001, 1'b0);
    check_frame("ar_frame", 1'b1);
    push_frame(16'h0000, 4'b0001, 1'b0);
    check_frame("ar_frame2", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed scan driver for a DIGITS-wide common-anode seven-segment display. Accepts a packed BCD value through a ready/load handshake, double-buffers it and commits it only at frame boundaries so a digit never tears. Cycles through the digits at a programmable refresh rate with leading-zero blanking and anti-ghosting dead time. Sits directly upstream of the `Segment` decoder: its `Din` output feeds the decoder's `Din` input, and `An` drives the digit anodes.

## Interface
- `DIGITS`, 4: number of digits; legal range 1..8.
- `REFRESH_DIV`, 1000: clock cycles per digit slot; must be at least 2.
- `BLANK_LZ`, 1: 1 enables leading-zero blanking; 0 never blanks.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `Load` in 1: offer `Value`; accepted on a rising edge when `Ready` is 1.
- `Value` in 4*DIGITS: packed BCD, digit 0 in bits [3:0].
- `Ready` out 1: high when the shadow buffer is empty.
- `Din` out 4: nibble for the current digit, to the `Segment` decoder.
- `Blank` out 1: current slot is dark.
- `An` out DIGITS: anode enables, active-low, at most one bit low.
- `Err` out 1: the displayed value contains a nibble greater than 9.

## Operation
- State: `cnt` (0..REFRESH_DIV-1), `idx` (0..DIGITS-1), `disp` (displayed value), `shadow`, `pending`.
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps from DIGITS-1 to 0.
- Frame length is DIGITS*REFRESH_DIV cycles. The frame boundary is the cycle where `cnt`=REFRESH_DIV-1 and `idx`=DIGITS-1.
- `Ready` = ~`pending`.
- `Load` with `Ready`=1: `shadow`<=`Value` and `pending`<=1.
- `Load` with `Ready`=0 is ignored and the offered value is discarded.
- At the frame boundary with `pending`=1:
  - `disp`<=`shadow` and `pending`<=0.
  - `Err`<=1 if any nibble of `shadow` is greater than 9, else 0.
- The boundary is the only cycle where `disp` and `Err` change.
- A `Load` on the boundary cycle cannot be accepted, because `Ready` is already 0.
- Digit `i` is blanked when `BLANK_LZ`=1, `i`>0, and nibbles `i`..DIGITS-1 of `disp` are all zero. Digit 0 is never blanked.
- Decode for the current slot:
  - `Din` = nibble `idx` of `disp`, passed through unmodified, including values greater than 9.
  - Dead time: when `cnt`=0, `An` is all ones and `Blank`=1.
  - When `cnt` is 1 or more and the digit is not blanked: `An` = ~(1<<`idx`) and `Blank`=0.
  - When `cnt` is 1 or more and the digit is blanked: `An` is all ones and `Blank`=1.

## Timing
- `An`, `Din` and `Blank` are registered. Each shows the decode of the previous cycle's (`cnt`, `idx`, `disp`), a latency of 1 cycle.
- `Ready` is combinational from `pending`. It falls the cycle after acceptance and rises the cycle after the boundary transfer.
- Worst-case load-to-display: one full frame, plus 1 cycle of transfer, plus 1 cycle of output register.
- Reset values:
  - `An`=all ones, `Blank`=1, `Din`=0, `Ready`=1, `Err`=0.
  - `cnt`=0, `idx`=0, `disp`=0, `pending`=0.
- Assertion of `rst_n` mid-frame clears all state immediately, with no clock needed. The anodes go dark at once.
- After reset deasserts, the first slot starts at `cnt`=0, i.e. with a dead-time cycle.

## Structure
- Package `seg_pkg` holds:
  - `DIGIT_W`=4.
  - `BCD_MAX`=9.
  - A function computing the blank mask from a packed value.
- Sub-module `seg_refresh_timer` holds `cnt` and `idx`. It exports `idx`, `slot_start` (`cnt`=0) and `frame_end`.
- The top level holds the buffers, the handshake and the output decode.
- The `Segment` decoder is instantiated by the parent and is not part of this block.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset held -> `An`=1111, `Blank`=1, `Din`=0, `Ready`=1, `Err`=0; these persist through the first dead-time cycle after release.
- Load 16'h1234 -> `Ready`=0 next cycle. After the boundary, each slot shows one dead cycle with `An`=1111, then 3 cycles of:
  - `Din`=4 with `An`=1110,
  - then `Din`=3 with `An`=1101,
  - then `Din`=2 with `An`=1011,
  - then `Din`=1 with `An`=0111.
  - `Ready` returns to 1.
- Leading zeros:
  - Load 16'h0005 -> digits 3..1 give `Blank`=1 and `An`=1111; digit 0 gives `Din`=5.
  - Load 16'h0000 -> only digit 0 lit, with `Din`=0.
  - With BLANK_LZ=0, all four digits are lit.
- Invalid digit:
  - Load 16'h00A3 -> `Err`=1 after the boundary; digit 1 gives `Din`=10 and is lit.
  - Then load 16'h0042 -> `Err`=0 at the next boundary.
- Load 16'h1111, then offer 16'h2222 while `Ready`=0 -> 1111 is displayed and 2222 never appears.
- Pulse `rst_n` low during slot 2 of a frame -> `An`=1111 asynchronously, `pending` is cleared, and the display restarts showing `disp`=0.
